// File: rtl/buffer_sequencer_if.sv
// Command/response channel between the pattern processor core and buffer_sequencer.
// One command in flight at a time; every accepted command yields exactly one response pulse.
interface buffer_sequencer_if #(
  parameter int buffer_width = 8
) ();
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [3:0]              cmd_arg;
  logic [buffer_width-1:0] cmd_data;
  logic                    rsp_valid;
  logic [buffer_width-1:0] rsp_data;
  logic                    rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/buffer_sequencer.sv
// Sequences processor READ/WRITE/NEXT_BUF/SELECT commands into registered buffer-bank
// controls, stalling field accesses to the buffer currently being serially loaded.
module buffer_sequencer #(
  parameter int buffer_size  = 12,
  parameter int buffer_width = 8,
  parameter int num_buffers  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  buffer_sequencer_if.slave       cmd,
  input  logic                    ser_busy,
  input  logic [2:0]              ser_addr,
  output logic [2:0]              bufp,
  output logic [2:0]              buffer_select,
  output logic [buffer_size-1:0]  fieldp,
  output logic [buffer_size-1:0]  fieldwp,
  output logic [buffer_width-1:0] field_in,
  output logic                    field_write,
  input  logic [buffer_width-1:0] field_byte
);

  typedef enum logic [2:0] {IDLE, STALL, SETUP, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_NEXT_BUF, OP_SELECT} op_t;

  localparam logic [buffer_size-1:0] FIELD0   = buffer_size'(1);
  localparam logic [2:0]             LAST_BUF = 3'(num_buffers - 1);

  state_t                  state_q, state_d;
  op_t                     op_q, cur_op;
  logic [3:0]              arg_q, cur_arg;
  logic [buffer_width-1:0] data_q, cur_data;
  logic                    err_q, cur_err;
  logic                    accept, conflict;

  // Bank outputs are loaded on the edge that enters SETUP; on the direct IDLE->SETUP
  // path the command is not latched yet, so the live command fields are used instead.
  always_comb begin
    accept   = cmd.cmd_valid & cmd.cmd_ready;
    conflict = ser_busy && (ser_addr == buffer_select);
    cur_op   = op_q;
    cur_arg  = arg_q;
    cur_data = data_q;
    if (state_q == IDLE) begin
      cur_op   = op_t'(cmd.cmd_op);
      cur_arg  = cmd.cmd_arg;
      cur_data = cmd.cmd_data;
    end
    cur_err = 1'b0;
    case (cur_op)
      OP_READ, OP_WRITE: cur_err = int'(cur_arg) >= buffer_size;
      OP_SELECT:         cur_err = int'(cur_arg) >= num_buffers;
      default:           cur_err = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((cur_op == OP_READ || cur_op == OP_WRITE) && conflict) state_d = STALL;
          else                                                       state_d = SETUP;
        end
      end
      STALL:   if (!conflict) state_d = SETUP;
      SETUP:   state_d = (op_q == OP_READ) ? ACCESS : RESP;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= OP_READ;
      arg_q         <= '0;
      data_q        <= '0;
      err_q         <= 1'b0;
      cmd.cmd_ready <= 1'b1;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_data  <= '0;
      cmd.rsp_err   <= 1'b0;
      bufp          <= '0;
      buffer_select <= '0;
      fieldp        <= FIELD0;
      fieldwp       <= FIELD0;
      field_in      <= '0;
      field_write   <= 1'b0;
    end else begin
      cmd.cmd_ready <= (state_d == IDLE);
      cmd.rsp_valid <= (state_d == RESP);
      cmd.rsp_err   <= (state_d == RESP) && err_q;
      cmd.rsp_data  <= (state_q == ACCESS && !err_q) ? field_byte : '0;
      field_write   <= 1'b0;

      if (accept) begin
        op_q   <= cur_op;
        arg_q  <= cur_arg;
        data_q <= cur_data;
        err_q  <= cur_err;
      end

      if (state_d == SETUP && !cur_err) begin
        case (cur_op)
          OP_READ:  fieldp <= FIELD0 << cur_arg;
          OP_WRITE: begin
            fieldwp     <= FIELD0 << cur_arg;
            field_in    <= cur_data;
            field_write <= 1'b1;
          end
          OP_NEXT_BUF: bufp <= (bufp == LAST_BUF) ? 3'd0 : bufp + 3'd1;
          OP_SELECT:   buffer_select <= cur_arg[2:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buffer_sequencer.sv
// Bench for buffer_sequencer: directed scenarios plus random commands, checked by a
// scoreboard against a behavioural model of the buffer bank contents and pointers.
module tb_buffer_sequencer;
  localparam int BS = 12;
  localparam int BW = 8;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ser_busy;
  logic [2:0]    ser_addr;
  logic [2:0]    bufp, buffer_select;
  logic [BS-1:0] fieldp, fieldwp;
  logic [BW-1:0] field_in, field_byte;
  logic          field_write;

  buffer_sequencer_if #(.buffer_width(BW)) bus ();

  buffer_sequencer #(.buffer_size(BS), .buffer_width(BW), .num_buffers(NB)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus),
    .ser_busy(ser_busy), .ser_addr(ser_addr),
    .bufp(bufp), .buffer_select(buffer_select),
    .fieldp(fieldp), .fieldwp(fieldwp),
    .field_in(field_in), .field_write(field_write),
    .field_byte(field_byte)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(int b, int f);
    return 8'((b * 37 + f * 11 + 5) & 255);
  endfunction

  function automatic int idx_of(logic [BS-1:0] oh);
    for (int i = 0; i < BS; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Buffer bank: registered read, so field_byte follows fieldp by one clock.
  logic [7:0] bank    [NB][BS];
  bit         written [NB][BS];
  always @(posedge clk) begin
    if (field_write) begin
      bank[buffer_select][idx_of(fieldwp)]    <= field_in;
      written[buffer_select][idx_of(fieldwp)] <= 1'b1;
    end
    field_byte <= written[buffer_select][idx_of(fieldp)] ? bank[buffer_select][idx_of(fieldp)]
                                                         : init_val(int'(buffer_select), idx_of(fieldp));
  end

  typedef struct {
    logic [7:0]    data;
    logic          err;
    logic [2:0]    bufp;
    logic [2:0]    sel;
    logic [BS-1:0] fp;
    logic [BS-1:0] fwp;
    int            lat;
    int            hs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   exp_writes = 0, obs_writes = 0;
  bit   rand_ser = 0;

  logic [7:0] mdl_mem [NB][BS];
  int         mdl_sel, mdl_bufp, mdl_rd, mdl_wr;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(logic [1:0] op, logic [3:0] arg, logic [7:0] data);
    exp_t e;
    e.data = '0;
    e.err  = 1'b0;
    case (op)
      2'd0: if (int'(arg) >= BS) e.err = 1'b1;
            else begin mdl_rd = int'(arg); e.data = mdl_mem[mdl_sel][arg]; end
      2'd1: if (int'(arg) >= BS) e.err = 1'b1;
            else begin mdl_mem[mdl_sel][arg] = data; mdl_wr = int'(arg); exp_writes++; end
      2'd2: mdl_bufp = (mdl_bufp + 1) % NB;
      default: if (int'(arg) >= NB) e.err = 1'b1; else mdl_sel = int'(arg);
    endcase
    e.bufp = 3'(mdl_bufp);
    e.sel  = 3'(mdl_sel);
    e.fp   = '0; e.fp[mdl_rd]  = 1'b1;
    e.fwp  = '0; e.fwp[mdl_wr] = 1'b1;
    e.lat  = -1;
    e.hs   = 0;
    return e;
  endfunction

  function automatic void model_reset();
    mdl_sel = 0; mdl_bufp = 0; mdl_rd = 0; mdl_wr = 0;
  endfunction

  // Call at a negedge; returns at the negedge of the cycle after the handshake.
  task automatic issue(logic [1:0] op, logic [3:0] arg, logic [7:0] data, int lat, bit track);
    exp_t e;
    int   waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: cmd_ready=%b after %0d cycles, expected 1", bus.cmd_ready, waited);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    bus.cmd_data  = data;
    if (track) begin
      e = model(op, arg, data);
      e.lat = (op == 2'd0 && e.err) ? -1 : lat;
      e.hs  = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  exp_t          mon_e;
  bit            prev_ok = 0, p_fw = 0, p_rsp = 0;
  logic [2:0]    p_bufp;
  logic [BS-1:0] p_fp, p_fwp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ok = 0;
    end else begin
      if (field_write) obs_writes++;
      check("fieldp_onehot", 32'($onehot(fieldp)), 1);
      check("fieldwp_onehot", 32'($onehot(fieldwp)), 1);
      if (prev_ok) begin
        if (p_fw) check("field_write_width", field_write, 0);
        if (bufp != p_bufp) check("bufp_with_field_change", (fieldp != p_fp) || (fieldwp != p_fwp), 0);
        if (p_rsp) check("cmd_ready_after_rsp", bus.cmd_ready, 1);
        if (!p_rsp) check("rsp_data_idle_zero", bus.rsp_valid ? 8'h00 : bus.rsp_data, 8'h00);
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%0h, expected no response", bus.rsp_data);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_data", bus.rsp_data, mon_e.data);
          check("rsp_err", bus.rsp_err, mon_e.err);
          check("bufp", bufp, mon_e.bufp);
          check("buffer_select", buffer_select, mon_e.sel);
          check("fieldp", fieldp, mon_e.fp);
          check("fieldwp", fieldwp, mon_e.fwp);
          if (mon_e.lat >= 0) check("rsp_latency", cyc - mon_e.hs, mon_e.lat);
        end
      end
      prev_ok = 1;
      p_fw    = field_write;
      p_rsp   = bus.rsp_valid;
      p_bufp  = bufp;
      p_fp    = fieldp;
      p_fwp   = fieldwp;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ser) begin
        ser_busy = ($urandom_range(0, 1) == 1);
        ser_addr = 3'($urandom_range(0, 7));
      end
    end
  end

  initial begin
    int         waited;
    logic [1:0] op;
    logic [3:0] arg;
    rst_n = 1'b0;
    ser_busy = 1'b0;
    ser_addr = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_arg   = '0;
    bus.cmd_data  = '0;
    for (int b = 0; b < NB; b++)
      for (int f = 0; f < BS; f++) mdl_mem[b][f] = init_val(b, f);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_bufp", bufp, 0);
    check("rst_buffer_select", buffer_select, 0);
    check("rst_fieldp", fieldp, 1);
    check("rst_fieldwp", fieldwp, 1);
    check("rst_field_in", field_in, 0);
    check("rst_field_write", field_write, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);

    issue(2'd1, 4'd5, 8'hA5, 2, 1);
    issue(2'd0, 4'd5, 8'h00, 3, 1);
    check("read5_fieldp_t1", fieldp, 32'h020);

    issue(2'd1, 4'd11, 8'h3C, 2, 1);
    check("write11_fieldwp_t1", fieldwp, 32'h800);
    check("write11_field_in_t1", field_in, 32'h3C);
    check("write11_field_write_t1", field_write, 1);
    @(negedge clk);
    check("write11_field_write_t2", field_write, 0);
    issue(2'd0, 4'd11, 8'h00, 3, 1);

    for (int i = 0; i < 8; i++) issue(2'd2, 4'd0, 8'h00, 2, 1);

    issue(2'd3, 4'd2, 8'h00, 2, 1);
    ser_addr = 3'd2;
    ser_busy = 1'b1;
    issue(2'd0, 4'd0, 8'h00, 6, 1);
    @(negedge clk);
    check("stall_no_rsp", bus.rsp_valid, 0);
    check("stall_fieldp_held", fieldp, 32'h800);
    @(negedge clk);
    ser_busy = 1'b0;
    ser_addr = 3'd4;
    ser_busy = 1'b1;
    issue(2'd0, 4'd7, 8'h00, 3, 1);
    ser_busy = 1'b0;

    issue(2'd1, 4'd12, 8'h55, 2, 1);
    issue(2'd3, 4'd9, 8'h00, 2, 1);

    issue(2'd1, 4'd3, 8'h77, 2, 0);
    check("rstw_field_write_pre", field_write, 1);
    #2 rst_n = 1'b0;
    #1;
    exp_writes++;
    model_reset();
    check("rstw_field_write", field_write, 0);
    check("rstw_fieldwp", fieldwp, 1);
    check("rstw_fieldp", fieldp, 1);
    check("rstw_field_in", field_in, 0);
    check("rstw_bufp", bufp, 0);
    check("rstw_buffer_select", buffer_select, 0);
    check("rstw_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw_cmd_ready_release", bus.cmd_ready, 1);
    repeat (4) @(negedge clk);
    issue(2'd0, 4'd3, 8'h00, 3, 1);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) rand_ser = 1;
      op  = 2'($urandom_range(0, 3));
      arg = (op == 2'd3) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 13));
      issue(op, arg, 8'($urandom_range(0, 255)),
            (rand_ser && op < 2'd2) ? -1 : ((op == 2'd0) ? 3 : 2), 1);
    end
    rand_ser = 0;
    @(negedge clk);
    ser_busy = 1'b0;

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    check("write_pulse_count", obs_writes, exp_writes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buffer_sequencer.md
# buffer_sequencer

Command-driven controller that sequences all processor-side access to the pattern buffer bank. It turns single READ/WRITE/NEXT_BUF/SELECT commands into the registered buffer-bank controls (bufp, buffer_select, one-hot fieldp/fieldwp, field_in, field_write). It enforces the bank rule that the buffer pointer and a field pointer never change in the same cycle. It also stalls field accesses to whichever buffer the serial loader is currently filling. It sits between the pattern processor core and the buffer bank, in the clk domain.

## Interface
- buffer_size, 12, fields per buffer; width of fieldp/fieldwp
- buffer_width, 8, bits per field
- num_buffers, 8, buffers addressable by bufp/buffer_select (≤ 8)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; handshake = cmd_valid & cmd_ready
- cmd_op  in  2  00 READ, 01 WRITE, 10 NEXT_BUF, 11 SELECT
- cmd_arg  in  4  field index (READ/WRITE), buffer number [2:0] (SELECT), ignored (NEXT_BUF)
- cmd_data  in  buffer_width  write data (WRITE)
- rsp_valid  out  1  one-cycle completion pulse, every command
- rsp_data  out  buffer_width  read data (READ), else 0
- rsp_err  out  1  valid with rsp_valid; field index ≥ buffer_size, or SELECT buffer ≥ num_buffers
- ser_busy  in  1  serial loader active
- ser_addr  in  3  buffer being serially loaded
- bufp  out  3  buffer pointer to bank
- buffer_select  out  3  buffer targeted by field access
- fieldp  out  buffer_size  one-hot read field pointer
- fieldwp  out  buffer_size  one-hot write field pointer
- field_in  out  buffer_width  write data to bank
- field_write  out  1  bank write strobe
- field_byte  in  buffer_width  bank read data, valid one clk after fieldp changes

## Operation
- States: IDLE, STALL, SETUP, ACCESS, RESP. All outputs registered.
- IDLE: cmd_ready=1. On handshake, latch op/arg/data.
  - READ/WRITE with ser_busy & ser_addr==buffer_select: go to STALL.
  - Otherwise go to SETUP.
- STALL: hold all bank outputs. Go to SETUP on the first cycle the conflict is clear. No timeout.
- SETUP:
  - READ: fieldp←1<<arg.
  - WRITE: fieldwp←1<<arg, field_in←data, field_write←1.
  - NEXT_BUF: bufp←bufp+1, wrapping num_buffers−1→0; fieldp/fieldwp held.
  - SELECT: buffer_select←arg[2:0].
  - Out-of-range index/buffer: no bank output changes, field_write stays 0, rsp_err set.
- ACCESS (READ only): capture field_byte into rsp_data.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- field_write is high for exactly one cycle per legal WRITE and never in any other state.
- fieldp and fieldwp are always exactly one-hot. Each holds its value until its next legal READ or WRITE.
- bufp changes only on NEXT_BUF, and never in a cycle where fieldp or fieldwp changes.
- A conflict check is made only at acceptance and in STALL. A ser_busy assertion after SETUP does not abort the access.

## Timing
- Handshake at cycle T.
- READ: fieldp valid T+1, field_byte sampled end of T+2, rsp_valid T+3, cmd_ready T+4.
- WRITE: field_write/fieldwp/field_in valid T+1 (write occurs at end of T+1), rsp_valid T+2, cmd_ready T+3.
- NEXT_BUF/SELECT: new bufp/buffer_select at T+1, rsp_valid T+2, cmd_ready T+3.
- A stall of N cycles delays every subsequent event by N.
- rsp_data is 0 for non-READ responses. It holds the read value only during rsp_valid.
- Reset (asynchronous, any state):
  - State IDLE; cmd_ready=1 after reset release.
  - bufp=0, buffer_select=0, fieldp=fieldwp=1 (field 0).
  - field_in=0, field_write=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - An in-flight command is dropped with no response. A field_write caught by reset drops immediately.

## Test plan
- Reset then READ arg=5 with bank returning 0xA5: fieldp=0x020 at T+1, rsp_valid at T+3 with rsp_data=0xA5, rsp_err=0.
- WRITE arg=11 data=0x3C: fieldwp=0x800, field_in=0x3C, field_write=1 for T+1 only; rsp_valid at T+2. A follow-up READ arg=11 returns 0x3C.
- Eight NEXT_BUF commands from reset: bufp steps 1..7 then 0. fieldp/fieldwp never change in those cycles.
- SELECT 2, ser_busy=1 ser_addr=2, READ arg=0: stays in STALL with rsp_valid=0 while busy. Drop ser_busy for 3 cycles later: rsp_valid arrives 3 cycles later than the unstalled case. Repeat with ser_addr=4: no stall.
- WRITE arg=12 and SELECT 9 (num_buffers=8): rsp_valid with rsp_err=1, field_write never asserted, fieldwp/buffer_select unchanged.
- Assert rst_n=0 during SETUP of a WRITE: field_write=0 immediately, all outputs at reset values, no rsp_valid; cmd_ready=1 on the first cycle after release.
